// File: rtl/airi5c_float_to_int_converter.sv
// ---------------------------------------------------------------------------
// airi5c_float_to_int_converter
//
// Multi-cycle FCVT.W.S / FCVT.WU.S unit. Converts a binary32 operand into a
// 32-bit signed or unsigned integer. The hidden-bit mantissa is shifted by the
// unbiased exponent into an integer part plus guard/sticky bits. The magnitude
// is then rounded and negated, and finally saturated to the destination range.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   kill         abort the in-flight operation
//   load         start a conversion, operands sampled this cycle
//   op_a         binary32 operand
//   unsigned_op  1 = FCVT.WU.S, 0 = FCVT.W.S
//   rm           resolved rounding mode (RNE/RTZ/RDN/RUP/RMM, 101..111 = RNE)
//   int_out      integer result (held until the next result)
//   ready        one-cycle pulse, int_out/NV/NX valid
//   NV           invalid flag
//   NX           inexact flag
//
// Configuration macro:
//   AIRI5C_FCVT_OUT_REG_EN  adds a register stage after saturation; the
//                           latency becomes 3 instead of 2.
// ---------------------------------------------------------------------------
module airi5c_float_to_int_converter (
    input  logic        clk,
    input  logic        reset,
    input  logic        kill,
    input  logic        load,
    input  logic [31:0] op_a,
    input  logic        unsigned_op,
    input  logic [2:0]  rm,
    output logic [31:0] int_out,
    output logic        ready,
    output logic        NV,
    output logic        NX
);

    // Rounding increment decision applied to the truncated magnitude; the
    // extra MSB keeps the carry for the range check.
    function automatic logic [32:0] round_mag(
        input logic [31:0] mag,
        input logic        g,
        input logic        s,
        input logic        sgn,
        input logic [2:0]  mode
    );
        logic inc;
        case (mode)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sgn & (g | s);
            3'b011:  inc = ~sgn & (g | s);
            3'b100:  inc = g;
            default: inc = g & (s | mag[0]);
        endcase
        return {1'b0, mag} + {32'd0, inc};
    endfunction

    // Returns {NV, result}. NaN and out-of-range inputs saturate; otherwise
    // the rounded magnitude is negated for negative inputs.
    function automatic logic [32:0] saturate(
        input logic [32:0] m,
        input logic        sgn,
        input logic        nan,
        input logic        big,
        input logic        uns
    );
        logic        ovf;
        logic [31:0] res;
        if (uns)
            ovf = big | m[32] | (sgn & (m != 33'd0));
        else
            ovf = big | (m > 33'h080000000) | ((m == 33'h080000000) & ~sgn);
        if (nan) begin
            res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            return {1'b1, res};
        end
        if (ovf) begin
            if (uns)
                res = sgn ? 32'h0000_0000 : 32'hFFFF_FFFF;
            else
                res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
            return {1'b1, res};
        end
        res = sgn ? (~m[31:0] + 32'd1) : m[31:0];
        return {1'b0, res};
    endfunction

    // ------------------------------------------------------------------
    // Stage 1 combinational: unpack, classify, align
    // ------------------------------------------------------------------
    logic               w_sign;
    logic [7:0]         w_exp;
    logic [22:0]        w_frac;
    logic               w_zero;
    logic               w_sub;
    logic               w_inf;
    logic               w_nan;
    logic signed [9:0]  w_e;
    logic [23:0]        w_mant;
    logic [63:0]        w_ext;
    logic [4:0]         w_rsh;
    logic [4:0]         w_lsh;
    logic [31:0]        w_int;
    logic               w_guard;
    logic               w_sticky;
    logic               w_big;

    assign w_sign = op_a[31];
    assign w_exp  = op_a[30:23];
    assign w_frac = op_a[22:0];
    assign w_zero = (w_exp == 8'd0) && (w_frac == 23'd0);
    assign w_sub  = (w_exp == 8'd0) && (w_frac != 23'd0);
    assign w_inf  = (w_exp == 8'hFF) && (w_frac == 23'd0);
    assign w_nan  = (w_exp == 8'hFF) && (w_frac != 23'd0);
    assign w_e    = $signed({2'b00, w_exp}) - 10'sd127;
    assign w_mant = {(w_exp != 8'd0), w_frac};

    always_comb begin
        w_ext    = '0;
        w_rsh    = '0;
        w_lsh    = '0;
        w_int    = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_big    = 1'b0;
        if (w_zero || w_nan) begin
            w_int = '0;
        end else if (w_inf || (w_e >= 10'sd32)) begin
            w_big = 1'b1;
        end else if (w_sub || (w_e < -10'sd1)) begin
            w_sticky = 1'b1;
        end else if (w_e == -10'sd1) begin
            w_guard  = 1'b1;
            w_sticky = |w_frac;
        end else if (w_e <= 10'sd23) begin
            // Mantissa placed at bits [55:32] so the 32 bits below the
            // integer part collect the shifted-out fraction.
            w_rsh    = 5'(10'sd23 - w_e);
            w_ext    = {8'd0, w_mant, 32'd0} >> w_rsh;
            w_int    = w_ext[63:32];
            w_guard  = w_ext[31];
            w_sticky = |w_ext[30:0];
        end else begin
            w_lsh = 5'(w_e - 10'sd23);
            w_int = {8'd0, w_mant} << w_lsh;
        end
    end

    logic               r_vld_p1;
    logic               r_sign_p1;
    logic               r_nan_p1;
    logic               r_big_p1;
    logic               r_uns_p1;
    logic [2:0]         r_rm_p1;
    logic [31:0]        r_int_p1;
    logic               r_guard_p1;
    logic               r_sticky_p1;

    always_ff @(posedge clk) begin
        if (reset)
            r_vld_p1 <= 1'b0;
        else
            r_vld_p1 <= load;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            r_sign_p1   <= w_sign;
            r_nan_p1    <= w_nan;
            r_big_p1    <= w_big;
            r_uns_p1    <= unsigned_op;
            r_rm_p1     <= rm;
            r_int_p1    <= w_int;
            r_guard_p1  <= w_guard;
            r_sticky_p1 <= w_sticky;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: round, negate, saturate
    // ------------------------------------------------------------------
    logic [32:0] w_mag_p1;
    logic [32:0] w_sat_p1;
    logic        w_nx_p1;
    logic        w_adv_p1;

    assign w_mag_p1 = round_mag(r_int_p1, r_guard_p1, r_sticky_p1, r_sign_p1, r_rm_p1);
    assign w_sat_p1 = saturate(w_mag_p1, r_sign_p1, r_nan_p1, r_big_p1, r_uns_p1);
    assign w_nx_p1  = ~w_sat_p1[32] & (r_guard_p1 | r_sticky_p1);
    // A new load or a kill drops whatever is in flight.
    assign w_adv_p1 = r_vld_p1 & ~kill & ~load;

`ifdef AIRI5C_FCVT_OUT_REG_EN
    logic        r_vld_p2;
    logic [31:0] r_res_p2;
    logic        r_nv_p2;
    logic        r_nx_p2;
    logic        w_adv_p2;

    always_ff @(posedge clk) begin
        if (reset)
            r_vld_p2 <= 1'b0;
        else
            r_vld_p2 <= w_adv_p1;
    end

    always_ff @(posedge clk) begin
        if (w_adv_p1) begin
            r_res_p2 <= w_sat_p1[31:0];
            r_nv_p2  <= w_sat_p1[32];
            r_nx_p2  <= w_nx_p1;
        end
    end

    assign w_adv_p2 = r_vld_p2 & ~kill & ~load;

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ready   <= 1'b0;
            int_out <= '0;
            NV      <= 1'b0;
            NX      <= 1'b0;
        end else begin
            ready <= w_adv_p2;
            if (w_adv_p2) begin
                int_out <= r_res_p2;
                NV      <= r_nv_p2;
                NX      <= r_nx_p2;
            end
        end
    end
`else
    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ready   <= 1'b0;
            int_out <= '0;
            NV      <= 1'b0;
            NX      <= 1'b0;
        end else begin
            ready <= w_adv_p1;
            if (w_adv_p1) begin
                int_out <= w_sat_p1[31:0];
                NV      <= w_sat_p1[32];
                NX      <= w_nx_p1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_airi5c_float_to_int_converter.sv
// ---------------------------------------------------------------------------
// Testbench for airi5c_float_to_int_converter: directed vector table plus
// hand-written kill / reload / reset sequences.
// ---------------------------------------------------------------------------
module tb_airi5c_float_to_int_converter;

`ifdef AIRI5C_FCVT_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic        kill;
    logic        load;
    logic [31:0] op_a;
    logic        unsigned_op;
    logic [2:0]  rm;
    logic [31:0] int_out;
    logic        ready;
    logic        NV;
    logic        NX;

    int tests;
    int fails;

    typedef struct {
        logic [31:0] op;
        logic        uns;
        logic [2:0]  rm;
        logic [31:0] res;
        logic        nv;
        logic        nx;
    } vec_t;

    vec_t vecs[$];

    airi5c_float_to_int_converter dut (
        .clk         (clk),
        .reset       (reset),
        .kill        (kill),
        .load        (load),
        .op_a        (op_a),
        .unsigned_op (unsigned_op),
        .rm          (rm),
        .int_out     (int_out),
        .ready       (ready),
        .NV          (NV),
        .NX          (NX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] op, input logic uns, input logic [2:0] m,
                       input logic [31:0] res, input logic nv, input logic nx);
        vec_t v;
        v.op = op; v.uns = uns; v.rm = m; v.res = res; v.nv = nv; v.nx = nx;
        vecs.push_back(v);
    endtask

    // Load one operand and check latency, result, flags and the single pulse.
    task automatic run_op(input vec_t v, input string nm);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge clk);
        op_a = v.op; unsigned_op = v.uns; rm = v.rm; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (ready) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: ready never seen, expected after %0d cycles", nm, LAT);
        end else begin
            chk({nm, " latency"}, 32'(lat), 32'(LAT));
            chk({nm, " int_out"}, int_out, v.res);
            chk({nm, " NV"}, {31'd0, NV}, {31'd0, v.nv});
            chk({nm, " NX"}, {31'd0, NX}, {31'd0, v.nx});
            @(negedge clk);
            chk({nm, " ready pulse"}, {31'd0, ready}, 32'd0);
        end
    endtask

    // Count ready pulses over a window starting at the current negedge.
    task automatic watch(output int cnt, output int first);
        cnt   = 0;
        first = 0;
        for (int c = 1; c <= 8; c++) begin
            if (ready) begin
                cnt++;
                if (first == 0) first = c;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        int first;
        vec_t v;

        tests = 0;
        fails = 0;
        reset = 1'b1; kill = 1'b0; load = 1'b0;
        op_a = '0; unsigned_op = 1'b0; rm = 3'b000;

        // op, uns, rm, result, NV, NX
        add(32'h40490FDB, 1'b0, 3'b000, 32'h00000003, 1'b0, 1'b1); // pi RNE
        add(32'hC0200000, 1'b0, 3'b000, 32'hFFFFFFFE, 1'b0, 1'b1); // -2.5 RNE
        add(32'hC0200000, 1'b0, 3'b001, 32'hFFFFFFFE, 1'b0, 1'b1); // -2.5 RTZ
        add(32'hC0200000, 1'b0, 3'b011, 32'hFFFFFFFE, 1'b0, 1'b1); // -2.5 RUP
        add(32'hC0200000, 1'b0, 3'b010, 32'hFFFFFFFD, 1'b0, 1'b1); // -2.5 RDN
        add(32'hC0200000, 1'b0, 3'b100, 32'hFFFFFFFD, 1'b0, 1'b1); // -2.5 RMM
        add(32'h4F000000, 1'b0, 3'b000, 32'h7FFFFFFF, 1'b1, 1'b0); // 2^31 signed
        add(32'h4F000000, 1'b1, 3'b000, 32'h80000000, 1'b0, 1'b0); // 2^31 unsigned
        add(32'hCF000000, 1'b0, 3'b000, 32'h80000000, 1'b0, 1'b0); // -2^31 signed
        add(32'hCF000001, 1'b0, 3'b000, 32'h80000000, 1'b1, 1'b0); // below -2^31
        add(32'h7FC00000, 1'b0, 3'b000, 32'h7FFFFFFF, 1'b1, 1'b0); // qNaN signed
        add(32'hFFC00000, 1'b1, 3'b000, 32'hFFFFFFFF, 1'b1, 1'b0); // -NaN unsigned
        add(32'hFF800000, 1'b1, 3'b000, 32'h00000000, 1'b1, 1'b0); // -inf unsigned
        add(32'h7F800000, 1'b0, 3'b000, 32'h7FFFFFFF, 1'b1, 1'b0); // +inf signed
        add(32'hBE99999A, 1'b1, 3'b001, 32'h00000000, 1'b0, 1'b1); // -0.3 unsigned RTZ
        add(32'hBF800000, 1'b1, 3'b000, 32'h00000000, 1'b1, 1'b0); // -1.0 unsigned
        add(32'h00000000, 1'b0, 3'b000, 32'h00000000, 1'b0, 1'b0); // +0
        add(32'h80000000, 1'b1, 3'b000, 32'h00000000, 1'b0, 1'b0); // -0 unsigned
        add(32'h3F000000, 1'b0, 3'b000, 32'h00000000, 1'b0, 1'b1); // 0.5 RNE -> 0
        add(32'h3FC00000, 1'b0, 3'b000, 32'h00000002, 1'b0, 1'b1); // 1.5 RNE -> 2
        add(32'h3F7FFFFF, 1'b0, 3'b011, 32'h00000001, 1'b0, 1'b1); // ~1 RUP
        add(32'h00000001, 1'b0, 3'b011, 32'h00000001, 1'b0, 1'b1); // subnormal RUP
        add(32'h4B000000, 1'b0, 3'b000, 32'h00800000, 1'b0, 1'b0); // 2^23 exact
        add(32'h4EFFFFFF, 1'b0, 3'b000, 32'h7FFFFF80, 1'b0, 1'b0); // largest < 2^31
        add(32'h4F7FFFFF, 1'b1, 3'b000, 32'hFFFFFF00, 1'b0, 1'b0); // largest < 2^32
        add(32'h4F800000, 1'b1, 3'b000, 32'hFFFFFFFF, 1'b1, 1'b0); // 2^32 unsigned
        add(32'h40400000, 1'b0, 3'b111, 32'h00000003, 1'b0, 1'b0); // rm 111 exact

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset ready", {31'd0, ready}, 32'd0);
        chk("reset int_out", int_out, 32'd0);
        chk("reset NV", {31'd0, NV}, 32'd0);
        chk("reset NX", {31'd0, NX}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i], $sformatf("vec%0d_%h", i, vecs[i].op));
        end

        // Known result before the abort sequences: pi -> 3, NX
        v = vecs[0];
        run_op(v, "pre_kill");

        // kill one cycle after load: no ready, outputs held
        @(negedge clk);
        op_a = 32'h3F800000; unsigned_op = 1'b0; rm = 3'b000; load = 1'b1;
        @(negedge clk);
        load = 1'b0; kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        watch(cnt, first);
        chk("kill ready count", 32'(cnt), 32'd0);
        chk("kill int_out held", int_out, 32'h00000003);
        chk("kill NV held", {31'd0, NV}, 32'd0);
        chk("kill NX held", {31'd0, NX}, 32'd1);

        // back-to-back load: only the newest operation completes
        @(negedge clk);
        op_a = 32'h3F800000; load = 1'b1;
        @(negedge clk);
        op_a = 32'h40000000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        watch(cnt, first);
        chk("reload ready count", 32'(cnt), 32'd1);
        chk("reload latency", 32'(first), 32'(LAT));
        chk("reload int_out", int_out, 32'h00000002);
        chk("reload NX", {31'd0, NX}, 32'd0);

        // kill together with a new load: old aborted, new accepted
        @(negedge clk);
        op_a = 32'h3F800000; load = 1'b1;
        @(negedge clk);
        op_a = 32'h40400000; load = 1'b1; kill = 1'b1;
        @(negedge clk);
        load = 1'b0; kill = 1'b0;
        watch(cnt, first);
        chk("kill+load ready count", 32'(cnt), 32'd1);
        chk("kill+load latency", 32'(first), 32'(LAT));
        chk("kill+load int_out", int_out, 32'h00000003);

        // reset one cycle after load: nothing completes, outputs cleared
        @(negedge clk);
        op_a = 32'hBFC00000; load = 1'b1;
        @(negedge clk);
        load = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        watch(cnt, first);
        chk("reset mid ready count", 32'(cnt), 32'd0);
        chk("reset mid int_out", int_out, 32'd0);
        chk("reset mid NV", {31'd0, NV}, 32'd0);
        chk("reset mid NX", {31'd0, NX}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
